// File: rtl/mmio_pkg.sv
// Shared definitions for the MMIO controller: bus command encodings,
// controller state type and the default address map.
package mmio_pkg;

    typedef enum logic [1:0] {
        MNONE    = 2'b00,
        MREAD    = 2'b01,
        MWRITE   = 2'b10,
        MILLEGAL = 2'b11
    } mem_cmd_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        RESP = 2'b10
    } state_e;

    localparam logic [8:0] DEF_LED_ADDR = 9'h100;
    localparam logic [8:0] DEF_SW_ADDR  = 9'h140;
    localparam logic [8:0] DEF_TMR_ADDR = 9'h180;

endpackage

// File: rtl/mmio_sync2.sv
// Two-flop synchroniser for asynchronous inputs. Output lags the input by
// two clock edges; both stages clear on the active-low asynchronous reset.
module mmio_sync2 #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    // First stage may go metastable; second stage gives it a cycle to settle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/mmio_ctrl.sv
// Memory-mapped I/O controller: RAM window in the lower half of the address
// space, plus LED register, switch port and an optional timer.
// Define MMIO_TIMER_EN to build the free-running timer at TMR_ADDR; without
// it that address decodes as unmapped and no timer registers exist.
module mmio_ctrl
    import mmio_pkg::*;
#(
    parameter int unsigned       DATA_W   = 16,
    parameter int unsigned       ADDR_W   = 9,
    parameter int unsigned       SW_W     = 8,
    parameter int unsigned       LED_W    = 8,
    parameter int unsigned       RD_WAIT  = 1,
    parameter logic [ADDR_W-1:0] LED_ADDR = ADDR_W'(DEF_LED_ADDR),
    parameter logic [ADDR_W-1:0] SW_ADDR  = ADDR_W'(DEF_SW_ADDR),
    parameter logic [ADDR_W-1:0] TMR_ADDR = ADDR_W'(DEF_TMR_ADDR)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        mem_cmd,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] write_data,
    output logic [DATA_W-1:0] read_data,
    output logic              rd_valid,
    output logic              busy,
    output logic              err,
    input  logic [SW_W-1:0]   sw_in,
    output logic [LED_W-1:0]  led_out,
    output logic [ADDR_W-2:0] ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout
);

    mem_cmd_e          cmd;
    state_e            state;
    logic [2:0]        wait_cnt;
    logic [ADDR_W-1:0] addr_q;
    logic [SW_W-1:0]   sw_sync;
    logic [DATA_W-1:0] rd_mux;
    logic              idle;
    logic              is_ram;
    logic              is_led;
    logic              is_sw;
    logic              is_tmr;
    logic              is_mapped;

    assign cmd       = mem_cmd_e'(mem_cmd);
    assign idle      = (state == IDLE);
    assign is_ram    = ~mem_addr[ADDR_W-1];
    assign is_led    = (mem_addr == LED_ADDR);
    assign is_sw     = (mem_addr == SW_ADDR);
    assign is_mapped = is_ram | is_led | is_sw | is_tmr;

    // The RAM follows the bus address while idle so a read's data is ready one
    // edge after acceptance; afterwards it holds the latched read address.
    assign ram_addr = idle ? mem_addr[ADDR_W-2:0] : addr_q[ADDR_W-2:0];
    assign ram_we   = idle && (cmd == MWRITE) && is_ram;
    assign ram_din  = write_data;

    mmio_sync2 #(
        .WIDTH (SW_W)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (sw_in),
        .q     (sw_sync)
    );

`ifdef MMIO_TIMER_EN
    logic [DATA_W-1:0] timer;
    logic [DATA_W-1:0] tmr_snap;

    assign is_tmr = (mem_addr == TMR_ADDR);

    // Free-running timer; a bus write to its address overrides the increment.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            timer <= '0;
        end else if (idle && (cmd == MWRITE) && is_tmr) begin
            timer <= write_data;
        end else begin
            timer <= timer + DATA_W'(1);
        end
    end

    // Capture the timer at read acceptance so the reply reflects that instant.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tmr_snap <= '0;
        end else if (idle && (cmd == MREAD)) begin
            tmr_snap <= timer;
        end
    end
`else
    // Timer address is decoded but forced off, so accesses fall through as unmapped.
    assign is_tmr = (mem_addr == TMR_ADDR) & 1'b0;
`endif

    // Select the reply for the latched read address; unmapped reads return zero.
    always_comb begin
        rd_mux = '0;
        if (!addr_q[ADDR_W-1]) begin
            rd_mux = ram_dout;
        end else if (addr_q == LED_ADDR) begin
            rd_mux = DATA_W'(led_out);
        end else if (addr_q == SW_ADDR) begin
            rd_mux = DATA_W'(sw_sync);
`ifdef MMIO_TIMER_EN
        end else if (addr_q == TMR_ADDR) begin
            rd_mux = tmr_snap;
`endif
        end
    end

    // Bus FSM: accepts commands only in IDLE, times the read wait, and owns all registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            addr_q    <= '0;
            read_data <= '0;
            rd_valid  <= 1'b0;
            busy      <= 1'b0;
            err       <= 1'b0;
            led_out   <= '0;
        end else begin
            rd_valid <= 1'b0;
            case (state)
                IDLE: begin
                    case (cmd)
                        MREAD: begin
                            addr_q   <= mem_addr;
                            wait_cnt <= 3'(RD_WAIT - 1);
                            state    <= WAIT;
                            busy     <= 1'b1;
                            if (!is_mapped) begin
                                err <= 1'b1;
                            end
                        end
                        MWRITE: begin
                            if (is_led) begin
                                led_out <= write_data[LED_W-1:0];
                            end else if (!is_ram && !is_tmr) begin
                                err <= 1'b1;
                            end
                        end
                        MILLEGAL: begin
                            err <= 1'b1;
                        end
                        default: begin
                        end
                    endcase
                end
                WAIT: begin
                    if (wait_cnt == 3'd0) begin
                        read_data <= rd_mux;
                        rd_valid  <= 1'b1;
                        state     <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt - 3'd1;
                    end
                end
                RESP: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mmio_ctrl.sv
// Self-checking bench for mmio_ctrl (RD_WAIT=3). A transaction-level model
// predicts every output each cycle; directed scenarios add literal checks.
// Build with MMIO_TIMER_EN defined to exercise the timer.
module tb_mmio_ctrl;
    import mmio_pkg::*;

    localparam int         RD_WAIT = 3;
    localparam logic [8:0] LED_A   = 9'h100;
    localparam logic [8:0] SW_A    = 9'h140;
    localparam logic [8:0] TMR_A   = 9'h180;
`ifdef MMIO_TIMER_EN
    localparam bit TMR_EN = 1'b1;
`else
    localparam bit TMR_EN = 1'b0;
`endif

    logic        clk        = 1'b0;
    logic        reset      = 1'b0;
    logic [1:0]  mem_cmd    = 2'b00;
    logic [8:0]  mem_addr   = '0;
    logic [15:0] write_data = '0;
    logic [7:0]  sw_in      = '0;
    logic [15:0] ram_dout   = '0;
    logic [15:0] read_data;
    logic        rd_valid;
    logic        busy;
    logic        err;
    logic [7:0]  led_out;
    logic [7:0]  ram_addr;
    logic        ram_we;
    logic [15:0] ram_din;

    int checks = 0;
    int errors = 0;
    bit checkEn = 1'b0;

    mmio_ctrl #(
        .DATA_W   (16),
        .ADDR_W   (9),
        .SW_W     (8),
        .LED_W    (8),
        .RD_WAIT  (RD_WAIT),
        .LED_ADDR (LED_A),
        .SW_ADDR  (SW_A),
        .TMR_ADDR (TMR_A)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .mem_cmd    (mem_cmd),
        .mem_addr   (mem_addr),
        .write_data (write_data),
        .read_data  (read_data),
        .rd_valid   (rd_valid),
        .busy       (busy),
        .err        (err),
        .sw_in      (sw_in),
        .led_out    (led_out),
        .ram_addr   (ram_addr),
        .ram_we     (ram_we),
        .ram_din    (ram_din),
        .ram_dout   (ram_dout)
    );

    always #5 clk = ~clk;

    // External synchronous RAM seen by the controller.
    logic [15:0] ram_mem [256];
    always @(posedge clk) begin
        if (ram_we) ram_mem[ram_addr] <= ram_din;
        ram_dout <= ram_mem[ram_addr];
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] cmd, input logic [8:0] addr, input logic [15:0] data);
        @(posedge clk);
        #1;
        mem_cmd    = cmd;
        mem_addr   = addr;
        write_data = data;
    endtask

    task automatic waitRdValid(output int edges);
        edges = 0;
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk);
            #1;
            if (rd_valid) begin
                edges = i;
                break;
            end
        end
    endtask

    function automatic bit mappedAddr(input logic [8:0] a);
        return !a[8] || a == LED_A || a == SW_A || (TMR_EN && a == TMR_A);
    endfunction

    // Transaction model: edges counted from reset, a read accepted at edge E
    // replies at E+RD_WAIT and frees the bus at E+RD_WAIT+1.
    int          cyc     = 0;
    int          m_free  = 0;
    int          m_resp  = -1;
    logic [8:0]  m_addr  = '0;
    logic [15:0] m_rdata = '0;
    logic [7:0]  m_led   = '0;
    logic        m_err   = 1'b0;
    logic [7:0]  m_sw1   = '0;
    logic [7:0]  m_sw2   = '0;
    logic [15:0] m_tmr   = '0;
    logic [15:0] m_snap  = '0;
    logic [15:0] m_mem [256];

    always @(posedge clk or negedge reset) begin
        bit tmrLoaded;
        if (!reset) begin
            m_free  = 0;
            m_resp  = -1;
            m_rdata = '0;
            m_led   = '0;
            m_err   = 1'b0;
            m_sw1   = '0;
            m_sw2   = '0;
            m_tmr   = '0;
            m_snap  = '0;
        end else begin
            cyc = cyc + 1;
            tmrLoaded = 1'b0;
            if (cyc == m_resp) begin
                if (!m_addr[8])                  m_rdata = m_mem[m_addr[7:0]];
                else if (m_addr == LED_A)        m_rdata = {8'h00, m_led};
                else if (m_addr == SW_A)         m_rdata = {8'h00, m_sw2};
                else if (TMR_EN && m_addr == TMR_A) m_rdata = m_snap;
                else                             m_rdata = '0;
            end
            if (cyc - 1 >= m_free) begin
                case (mem_cmd)
                    2'b01: begin
                        m_addr = mem_addr;
                        m_snap = m_tmr;
                        m_resp = cyc + RD_WAIT;
                        m_free = cyc + RD_WAIT + 1;
                        if (!mappedAddr(mem_addr)) m_err = 1'b1;
                    end
                    2'b10: begin
                        if (!mem_addr[8]) m_mem[mem_addr[7:0]] = write_data;
                        else if (mem_addr == LED_A) m_led = write_data[7:0];
                        else if (TMR_EN && mem_addr == TMR_A) begin
                            m_tmr = write_data;
                            tmrLoaded = 1'b1;
                        end else m_err = 1'b1;
                    end
                    2'b11: m_err = 1'b1;
                    default: ;
                endcase
            end
            if (!tmrLoaded) m_tmr = m_tmr + 16'd1;
            m_sw2 = m_sw1;
            m_sw1 = sw_in;
        end
    end

    // Mid-cycle comparison of every output against the model.
    always @(negedge clk) begin
        bit idleNow;
        if (checkEn) begin
            idleNow = (cyc >= m_free);
            checkOutput("busy", 32'(busy), 32'(!idleNow));
            checkOutput("rd_valid", 32'(rd_valid), 32'(cyc == m_resp));
            checkOutput("read_data", 32'(read_data), 32'(m_rdata));
            checkOutput("err", 32'(err), 32'(m_err));
            checkOutput("led_out", 32'(led_out), 32'(m_led));
            checkOutput("ram_we", 32'(ram_we), 32'(idleNow && mem_cmd == 2'b10 && !mem_addr[8]));
            checkOutput("ram_addr", 32'(ram_addr), 32'(idleNow ? mem_addr[7:0] : m_addr[7:0]));
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int k;
        int hits;
        for (int i = 0; i < 256; i++) begin
            ram_mem[i] = '0;
            m_mem[i]   = '0;
        end

        repeat (2) @(posedge clk);
        #1;
        checkEn = 1'b1;
        checkOutput("rst_read_data", 32'(read_data), 32'h0);
        checkOutput("rst_busy", 32'(busy), 32'h0);
        checkOutput("rst_err", 32'(err), 32'h0);
        checkOutput("rst_led", 32'(led_out), 32'h0);
        reset = 1'b1;

        $display("[TB] LED write");
        applyStimulus(MWRITE, 9'h100, 16'h00A5);
        applyStimulus(MNONE, 9'h000, 16'h0000);
        checkOutput("led_a5", 32'(led_out), 32'hA5);
        checkOutput("led_busy", 32'(busy), 32'h0);
        checkOutput("led_err", 32'(err), 32'h0);

        $display("[TB] RAM write then read");
        applyStimulus(MWRITE, 9'h010, 16'h1234);
        applyStimulus(MREAD, 9'h010, 16'h0000);
        applyStimulus(MNONE, 9'h000, 16'h0000);
        waitRdValid(k);
        checkOutput("ram_rd_latency", 32'(k), 32'd3);
        checkOutput("ram_rd_data", 32'(read_data), 32'h1234);
        @(posedge clk);
        #1;
        checkOutput("ram_rd_pulse", 32'(rd_valid), 32'h0);
        checkOutput("ram_rd_idle", 32'(busy), 32'h0);

        $display("[TB] commands while busy");
        applyStimulus(MREAD, 9'h010, 16'h0000);
        applyStimulus(MILLEGAL, 9'h010, 16'h0000);
        applyStimulus(MWRITE, 9'h100, 16'h00FF);
        applyStimulus(MREAD, 9'h1F0, 16'h0000);
        applyStimulus(MNONE, 9'h000, 16'h0000);
        checkOutput("busy_rd_valid", 32'(rd_valid), 32'h1);
        checkOutput("busy_rd_data", 32'(read_data), 32'h1234);
        checkOutput("busy_err", 32'(err), 32'h0);
        checkOutput("busy_led", 32'(led_out), 32'hA5);
        hits = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            if (rd_valid) hits++;
        end
        checkOutput("busy_no_second", 32'(hits), 32'h0);

        $display("[TB] switch read");
        sw_in = 8'h3C;
        applyStimulus(MNONE, 9'h000, 16'h0000);
        applyStimulus(MNONE, 9'h000, 16'h0000);
        applyStimulus(MREAD, 9'h140, 16'h0000);
        applyStimulus(MNONE, 9'h000, 16'h0000);
        waitRdValid(k);
        checkOutput("sw_latency", 32'(k), 32'd3);
        checkOutput("sw_data", 32'(read_data), 32'h003C);

        $display("[TB] timer write and read");
        applyStimulus(MWRITE, 9'h180, 16'hFFFE);
        applyStimulus(MNONE, 9'h000, 16'h0000);
        applyStimulus(MNONE, 9'h000, 16'h0000);
        applyStimulus(MREAD, 9'h180, 16'h0000);
        applyStimulus(MNONE, 9'h000, 16'h0000);
        waitRdValid(k);
        checkOutput("tmr_data", 32'(read_data), 32'h0000);
        checkOutput("tmr_err", 32'(err), TMR_EN ? 32'h0 : 32'h1);

        $display("[TB] LED read, unmapped read, illegal command");
        applyStimulus(MREAD, 9'h100, 16'h0000);
        applyStimulus(MNONE, 9'h000, 16'h0000);
        waitRdValid(k);
        checkOutput("led_rd_data", 32'(read_data), 32'h00A5);
        applyStimulus(MREAD, 9'h1F0, 16'h0000);
        applyStimulus(MNONE, 9'h000, 16'h0000);
        waitRdValid(k);
        checkOutput("unmap_latency", 32'(k), 32'd3);
        checkOutput("unmap_data", 32'(read_data), 32'h0000);
        checkOutput("unmap_err", 32'(err), 32'h1);
        applyStimulus(MILLEGAL, 9'h000, 16'h0000);
        applyStimulus(MNONE, 9'h000, 16'h0000);
        checkOutput("illegal_err", 32'(err), 32'h1);
        checkOutput("illegal_busy", 32'(busy), 32'h0);

        $display("[TB] reset during read wait");
        applyStimulus(MREAD, 9'h010, 16'h0000);
        applyStimulus(MNONE, 9'h000, 16'h0000);
        #2;
        reset = 1'b0;
        #1;
        checkOutput("arst_read_data", 32'(read_data), 32'h0);
        checkOutput("arst_rd_valid", 32'(rd_valid), 32'h0);
        checkOutput("arst_busy", 32'(busy), 32'h0);
        checkOutput("arst_err", 32'(err), 32'h0);
        checkOutput("arst_led", 32'(led_out), 32'h0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        hits = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            if (rd_valid) hits++;
        end
        checkOutput("arst_no_resp", 32'(hits), 32'h0);

        checkEn = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mmio_ctrl.md
MMIO_CTRL -- requirements
Module: mmio_ctrl

Interface
REQ-001 Parameters, one per line: name, default, meaning; all SHALL be honoured.
  DATA_W, 16, bus data width
  ADDR_W, 9, bus address width
  SW_W, 8, switch input width (SW_W <= DATA_W)
  LED_W, 8, LED register width (LED_W <= DATA_W)
  RD_WAIT, 1, read wait cycles (1..7)
  LED_ADDR, 9'h100, LED register address
  SW_ADDR, 9'h140, switch port address
  TMR_ADDR, 9'h180, timer address
REQ-002 Ports, one per line: name  direction  width  meaning; all SHALL exist as listed.
  clk  in  1  single clock, rising edge
  reset  in  1  asynchronous, active-low reset
  mem_cmd  in  2  bus command: 00 none, 01 read, 10 write, 11 illegal
  mem_addr  in  ADDR_W  bus address
  write_data  in  DATA_W  bus write data
  read_data  out  DATA_W  registered read response
  rd_valid  out  1  read response strobe
  busy  out  1  read in progress
  err  out  1  sticky access-error flag
  sw_in  in  SW_W  raw asynchronous switch inputs
  led_out  out  LED_W  LED register
  ram_addr  out  ADDR_W-1  external synchronous RAM address
  ram_we  out  1  RAM write enable
  ram_din  out  DATA_W  RAM write data
  ram_dout  in  DATA_W  RAM read data, valid one edge after address

Function
REQ-003 RAM region SHALL be mem_addr[ADDR_W-1]==0; LED_ADDR, SW_ADDR, TMR_ADDR SHALL be the only other mapped addresses.
REQ-004 FSM SHALL have states IDLE, WAIT, RESP; commands SHALL be accepted only in IDLE; busy SHALL be high in WAIT and RESP.
REQ-005 Read accepted at edge E0 SHALL latch the address, enter WAIT, and count RD_WAIT-1 further cycles in WAIT.
REQ-006 At edge E0+RD_WAIT the block SHALL load read_data, enter RESP, and hold rd_valid high for exactly one cycle, then return to IDLE.
REQ-007 Read data SHALL be: RAM -> ram_dout; LED_ADDR -> led_out zero-extended; SW_ADDR -> synchronised switches zero-extended; TMR_ADDR -> timer value sampled at E0; unmapped -> 0.
REQ-008 read_data SHALL hold its last value outside RESP.
REQ-009 In IDLE, ram_addr SHALL equal mem_addr[ADDR_W-2:0]; in WAIT/RESP it SHALL hold the latched address.
REQ-010 Write in IDLE SHALL complete in one cycle: RAM write via ram_we=1 with ram_din=write_data in that cycle, or LED register load of write_data[LED_W-1:0] at the edge; write SHALL never set busy.
REQ-011 sw_in SHALL pass through a two-flop synchroniser, giving two cycles of input-to-readable latency.
REQ-012 err SHALL set on: mem_cmd==11 in IDLE, read/write to an unmapped address, or write to SW_ADDR; the offending access SHALL have no other effect except that an unmapped read still completes with data 0.
REQ-013 Commands presented while busy SHALL be ignored without setting err.
REQ-014 ram_we SHALL be 0 in every cycle other than an accepted RAM write.

Reset
REQ-015 reset low SHALL asynchronously force IDLE, read_data=0, rd_valid=0, busy=0, err=0, led_out=0, synchroniser flops=0, timer=0, including mid-read; no response SHALL follow for an aborted read.

Configuration
REQ-016 With MMIO_TIMER_EN defined, a DATA_W-bit free-running timer SHALL increment every cycle, wrap to 0, and load write_data on a write to TMR_ADDR, where that write takes priority over increment.
REQ-017 Without MMIO_TIMER_EN, TMR_ADDR SHALL be unmapped per REQ-012, and no timer flops SHALL exist.

Structure
REQ-018 Shared package mmio_pkg SHALL hold the mem_cmd encodings (MNONE, MREAD, MWRITE), the FSM state type, and the default map addresses.
REQ-019 The synchroniser SHALL be sub-module mmio_sync2, parametrised by width, with the same reset.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
  Write 16'h00A5 to 9'h100 -> led_out=8'hA5 after that edge; busy stays 0; err=0.
  Write 16'h1234 to RAM 9'h010, then read 9'h010 with RD_WAIT=3 -> rd_valid one cycle, 3 edges after accept; read_data=16'h1234.
  sw_in=8'h3C, wait 2 cycles, read 9'h140 -> read_data=16'h003C.
  Read 9'h1F0, then issue mem_cmd=11 -> read_data=0, err=1 sticky; second read issued while busy is ignored.
  MMIO_TIMER_EN: write 16'hFFFE to 9'h180, read 2 cycles later -> value wraps through 0; without macro -> 0 and err=1.
  reset low during WAIT -> rd_valid never asserts; all outputs 0 immediately.
